// File: rtl/data_bus_subsys.sv
// Data-side memory subsystem: decodes MEM-stage bus accesses to a word RAM,
// a peripheral block (LED register, compare timer) or unmapped space.
module data_bus_subsys #(
    parameter int          RAM_WORDS   = 256,
    parameter int          LED_WIDTH   = 16,
    parameter logic [31:0] PERIPH_BASE = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          bAddr,
    input  logic [31:0]          bWData,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    output logic [31:0]          bRData,
    output logic [LED_WIDTH-1:0] leds,
    output logic                 timer_irq,
    output logic                 bus_err
);

    localparam int RAM_AW = $clog2(RAM_WORDS);

    logic [31:0]          mem [RAM_WORDS];

    logic [LED_WIDTH-1:0] leds_q,   leds_d;
    logic [31:0]          cnt_q,    cnt_d;
    logic [31:0]          cmp_q,    cmp_d;
    logic                 en_q,     en_d;
    logic                 aclr_q,   aclr_d;
    logic                 match_q,  match_d;
    logic                 irqen_q,  irqen_d;
    logic [15:0]          errcnt_q, errcnt_d;
    logic                 bus_err_q, bus_err_d;

    logic                 ram_hit_s;
    logic                 per_hit_s;
    logic                 unmapped_s;
    logic [2:0]           per_sel_s;
    logic [RAM_AW-1:0]    ram_idx_s;
    logic                 wr_per_s;
    logic                 match_set_s;
    logic [31:0]          per_rdata_s;
    logic                 unused_s;

    assign unused_s   = ^bAddr[1:0];
    assign per_sel_s  = bAddr[4:2];
    assign ram_idx_s  = bAddr[RAM_AW+1:2];
    assign ram_hit_s  = (bAddr[31:RAM_AW+2] == {(30-RAM_AW){1'b0}});
    assign per_hit_s  = !ram_hit_s && (bAddr[31:5] == PERIPH_BASE[31:5]) && (per_sel_s <= 3'd4);
    assign unmapped_s = (MemRead || MemWrite) && !ram_hit_s && !per_hit_s;
    assign wr_per_s   = MemWrite && per_hit_s;
    assign match_set_s = en_q && (cnt_q == cmp_q);

    // Peripheral read mux
    always_comb begin
        per_rdata_s = 32'h0000_0000;
        case (per_sel_s)
            3'd0:    per_rdata_s = 32'(leds_q);
            3'd1:    per_rdata_s = cnt_q;
            3'd2:    per_rdata_s = cmp_q;
            3'd3:    per_rdata_s = {28'h000_0000, irqen_q, match_q, aclr_q, en_q};
            3'd4:    per_rdata_s = {16'h0000, errcnt_q};
            default: per_rdata_s = 32'h0000_0000;
        endcase
    end

    // Combinational read data; reflects pre-write state during a read-modify cycle
    always_comb begin
        bRData = 32'h0000_0000;
        if (!MemRead) begin
            bRData = 32'h0000_0000;
        end else if (ram_hit_s) begin
            bRData = mem[ram_idx_s];
        end else if (per_hit_s) begin
            bRData = per_rdata_s;
        end else begin
            bRData = 32'h0000_0000;
        end
    end

    // Next-state for peripheral registers, timer and error tracking
    always_comb begin
        leds_d    = leds_q;
        cnt_d     = cnt_q;
        cmp_d     = cmp_q;
        en_d      = en_q;
        aclr_d    = aclr_q;
        match_d   = match_q;
        irqen_d   = irqen_q;
        errcnt_d  = errcnt_q;
        bus_err_d = unmapped_s;

        if (en_q) begin
            if (match_set_s && aclr_q) begin
                cnt_d = 32'h0000_0000;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end

        if (wr_per_s) begin
            case (per_sel_s)
                3'd0: leds_d = bWData[LED_WIDTH-1:0];
                3'd1: cnt_d  = bWData;
                3'd2: cmp_d  = bWData;
                3'd3: begin
                    en_d    = bWData[0];
                    aclr_d  = bWData[1];
                    irqen_d = bWData[3];
                    if (bWData[2]) begin
                        match_d = 1'b0;
                    end else begin
                        match_d = match_q;
                    end
                end
                default: leds_d = leds_q;
            endcase
        end else begin
            leds_d = leds_q;
        end

        // A match in the same cycle beats a write-1-to-clear
        if (match_set_s) begin
            match_d = 1'b1;
        end else begin
            match_d = match_d;
        end

        if (unmapped_s && (errcnt_q != 16'hFFFF)) begin
            errcnt_d = errcnt_q + 16'd1;
        end else begin
            errcnt_d = errcnt_q;
        end
    end

    // Register state with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leds_q    <= {LED_WIDTH{1'b0}};
            cnt_q     <= 32'h0000_0000;
            cmp_q     <= 32'hFFFF_FFFF;
            en_q      <= 1'b0;
            aclr_q    <= 1'b0;
            match_q   <= 1'b0;
            irqen_q   <= 1'b0;
            errcnt_q  <= 16'h0000;
            bus_err_q <= 1'b0;
        end else begin
            leds_q    <= leds_d;
            cnt_q     <= cnt_d;
            cmp_q     <= cmp_d;
            en_q      <= en_d;
            aclr_q    <= aclr_d;
            match_q   <= match_d;
            irqen_q   <= irqen_d;
            errcnt_q  <= errcnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    // RAM write port; not reset, but a write presented under reset is dropped
    always_ff @(posedge clk) begin
        if (rst_n && MemWrite && ram_hit_s) begin
            mem[ram_idx_s] <= bWData;
        end
    end

    assign leds      = leds_q;
    assign timer_irq = match_q & irqen_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_data_bus_subsys.sv
// Directed self-checking bench for data_bus_subsys.
module tb_data_bus_subsys;

    logic        clk;
    logic        rst_n;
    logic [31:0] bAddr;
    logic [31:0] bWData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] bRData;
    logic [15:0] leds;
    logic        timer_irq;
    logic        bus_err;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] A_LED   = 32'h8000_0000;
    localparam logic [31:0] A_COUNT = 32'h8000_0004;
    localparam logic [31:0] A_CMP   = 32'h8000_0008;
    localparam logic [31:0] A_CTRL  = 32'h8000_000C;
    localparam logic [31:0] A_ERR   = 32'h8000_0010;

    data_bus_subsys dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bAddr     (bAddr),
        .bWData    (bWData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .bRData    (bRData),
        .leds      (leds),
        .timer_irq (timer_irq),
        .bus_err   (bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bAddr = a; bWData = d; MemWrite = 1'b1; MemRead = 1'b0;
        @(posedge clk);
        #1 MemWrite = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] v);
        @(negedge clk);
        bAddr = a; MemRead = 1'b1; MemWrite = 1'b0;
        #1 v = bRData;
        @(posedge clk);
        #1 MemRead = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        bit          found;

        rst_n = 1'b0; bAddr = 32'h0; bWData = 32'h0; MemRead = 1'b0; MemWrite = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Reset state
        check_eq("rst_leds", 32'(leds), 32'h0);
        check_eq("rst_irq", 32'(timer_irq), 32'h0);
        check_eq("rst_buserr", 32'(bus_err), 32'h0);
        do_read(A_COUNT, v); check_eq("rst_count", v, 32'h0);
        do_read(A_CMP, v);   check_eq("rst_cmp", v, 32'hFFFF_FFFF);
        do_read(A_CTRL, v);  check_eq("rst_ctrl", v, 32'h0);
        do_read(A_ERR, v);   check_eq("rst_errcnt", v, 32'h0);

        // RAM write / readback, low address bits ignored, MemRead gating
        do_write(32'h0000_0010, 32'h1234_5678);
        do_read(32'h0000_0010, v); check_eq("ram_rd", v, 32'h1234_5678);
        do_read(32'h0000_0013, v); check_eq("ram_rd_lowbits", v, 32'h1234_5678);
        @(negedge clk); bAddr = 32'h0000_0010; MemRead = 1'b0;
        #1 check_eq("ram_no_rd", bRData, 32'h0);

        // Read during write shows old data
        do_write(32'h0000_0010, 32'h0000_000A);
        @(negedge clk);
        bAddr = 32'h0000_0010; bWData = 32'h0000_000B; MemRead = 1'b1; MemWrite = 1'b1;
        #1 check_eq("rdw_old", bRData, 32'h0000_000A);
        @(posedge clk); #1 MemWrite = 1'b0;
        @(negedge clk); #1 check_eq("rdw_new", bRData, 32'h0000_000B);
        MemRead = 1'b0;

        // LED register and reset mid-access
        do_write(32'h0000_0020, 32'h0000_0055);
        do_write(A_LED, 32'hFFFF_ABCD);
        check_eq("led_out", 32'(leds), 32'h0000_ABCD);
        do_read(A_LED, v); check_eq("led_rd", v, 32'h0000_ABCD);
        @(negedge clk);
        bAddr = 32'h0000_0020; bWData = 32'h0000_0066; MemWrite = 1'b1; rst_n = 1'b0;
        #1 check_eq("led_async_rst", 32'(leds), 32'h0);
        @(posedge clk);
        @(negedge clk); MemWrite = 1'b0; rst_n = 1'b1;
        do_read(32'h0000_0020, v); check_eq("rst_drop_wr", v, 32'h0000_0055);

        // Timer match with auto-clear and IRQ
        do_write(A_CMP, 32'd5);
        do_write(A_COUNT, 32'd0);
        do_write(A_CTRL, 32'h0000_000B);
        for (int i = 0; i < 6; i++) begin
            do_read(A_COUNT, v);
            check_eq($sformatf("tmr_count%0d", i), v, 32'(i));
        end
        do_read(A_COUNT, v); check_eq("tmr_autoclr", v, 32'd0);
        check_eq("tmr_irq_set", 32'(timer_irq), 32'h1);
        do_read(A_CTRL, v); check_eq("tmr_ctrl_match", v, 32'h0000_000F);
        do_write(A_CTRL, 32'h0000_000F);
        check_eq("tmr_irq_clr", 32'(timer_irq), 32'h0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            do_read(A_COUNT, v);
            if (v == 32'd4) found = 1'b1;
        end
        check_eq("tmr_wait_4", 32'(found), 32'h1);
        do_write(A_CTRL, 32'h0000_000F);
        check_eq("tmr_match_wins", 32'(timer_irq), 32'h1);
        do_read(A_COUNT, v); check_eq("tmr_autoclr2", v, 32'd0);
        do_read(A_CTRL, v); check_eq("tmr_ctrl_sticky", v, 32'h0000_000F);
        do_write(A_CTRL, 32'h0000_0004);
        check_eq("tmr_irq_off", 32'(timer_irq), 32'h0);

        // Timer wrap without match, then write override
        do_write(A_COUNT, 32'hFFFF_FFFE);
        do_write(A_CMP, 32'd3);
        do_write(A_CTRL, 32'h0000_0001);
        do_read(A_COUNT, v); check_eq("wrap_fffe", v, 32'hFFFF_FFFE);
        do_read(A_COUNT, v); check_eq("wrap_ffff", v, 32'hFFFF_FFFF);
        do_read(A_COUNT, v); check_eq("wrap_0", v, 32'h0);
        do_read(A_COUNT, v); check_eq("wrap_1", v, 32'h1);
        do_write(A_COUNT, 32'h0000_0100);
        do_read(A_COUNT, v); check_eq("cnt_override", v, 32'h0000_0100);
        do_read(A_CTRL, v); check_eq("wrap_no_match", v, 32'h0000_0001);
        do_write(A_CTRL, 32'h0000_0000);

        // Bus errors and ERRCNT saturation
        do_read(32'h4000_0000, v); check_eq("unmap_rd", v, 32'h0);
        check_eq("buserr_pulse", 32'(bus_err), 32'h1);
        do_read(A_ERR, v); check_eq("errcnt_1", v, 32'd1);
        check_eq("buserr_drop", 32'(bus_err), 32'h0);
        do_read(32'h8000_0014, v); check_eq("unmap_per_rd", v, 32'h0);
        do_write(A_ERR, 32'h0000_1234);
        do_read(A_ERR, v); check_eq("errcnt_2_ro", v, 32'd2);
        @(negedge clk); bAddr = 32'h0001_0000; MemWrite = 1'b1;
        repeat (65540) @(posedge clk);
        #1 MemWrite = 1'b0;
        do_read(A_ERR, v); check_eq("errcnt_sat", v, 32'h0000_FFFF);
        do_read(A_LED, v); check_eq("led_unaffected", v, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/data_bus_subsys.md
# data_bus_subsys

Data-side memory subsystem on the core's MEM-stage bus (bAddr, bWData, bRData, MemRead, MemWrite). Decodes each access to one of three targets: a word-addressed data RAM, a memory-mapped peripheral block (LED register and a 32-bit compare timer with interrupt), or unmapped space. It also counts bus errors. Reads are combinational so that bRData is valid in the same cycle the MEM stage presents the address; all state updates happen on the rising clock edge.

## Interface
- RAM_WORDS, 256: data RAM depth in 32-bit words; must be a power of 2 and ≤ 1024.
- LED_WIDTH, 16: width of the LED output register.
- PERIPH_BASE, 32'h8000_0000: base address of the peripheral window.

- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bAddr  in  32  byte address from the MEM stage.
- bWData  in  32  write data.
- MemRead  in  1  read strobe, one cycle per access.
- MemWrite  in  1  write strobe, one cycle per access.
- bRData  out  32  read data, combinational from bAddr and current state.
- leds  out  LED_WIDTH  LED register contents.
- timer_irq  out  1  level interrupt = MATCH & IRQ_EN.
- bus_err  out  1  registered one-cycle pulse on an unmapped access.

## Operation
- All accesses are whole-word; bAddr[1:0] is ignored.
- Address decode:
  - RAM when bAddr < RAM_WORDS*4; index bAddr[log2(RAM_WORDS)+1:2].
  - Peripheral when bAddr[31:5] == PERIPH_BASE[31:5] and the offset is one of the defined registers.
  - Everything else is unmapped.
- Peripheral registers (offset from PERIPH_BASE):
  - 0x00 LED: RW, low LED_WIDTH bits; upper bits read 0.
  - 0x04 COUNT: RW timer count.
  - 0x08 CMP: RW compare value.
  - 0x0C CTRL: bit0 EN, bit1 AUTO_CLR, bit2 MATCH (sticky; write 1 to clear, writing 0 has no effect), bit3 IRQ_EN. Bits 31:4 read 0.
  - 0x10 ERRCNT: RO 16-bit saturating unmapped-access counter, zero-extended on read; writes ignored.
  - Offsets 0x14–0x1F are unmapped.
- Reads:
  - bRData returns the target's current value.
  - Unmapped reads return 32'h0.
  - When MemRead = 0, bRData = 0.
- Writes: performed at the rising edge when MemWrite = 1.
- MemRead and MemWrite both high: the write is performed; bRData shows the pre-write value.
- Timer, each cycle with EN = 1:
  - If COUNT == CMP: set MATCH; next COUNT = AUTO_CLR ? 0 : COUNT+1.
  - Otherwise COUNT = COUNT+1, wrapping 0xFFFF_FFFF → 0 without setting MATCH.
  - With EN = 0, COUNT holds.
- Simultaneous events:
  - A bus write to COUNT overrides the increment or clear that cycle.
  - A match setting MATCH wins over a same-cycle write-1-to-clear.
  - A CTRL write takes effect next cycle; the current cycle uses the old EN.
- Unmapped access (MemRead | MemWrite):
  - bus_err pulses high the following cycle.
  - ERRCNT increments, saturating at 0xFFFF.
  - The RAM and all registers are unaffected.

## Timing
- Read latency 0 cycles: combinational from bAddr/MemRead to bRData.
- Write latency 1 edge: a read of the same address in the next cycle returns the new value.
- timer_irq is combinational from the registered MATCH/IRQ_EN bits, so it rises the cycle after the matching edge.
- Reset (rst_n low, asynchronous):
  - leds = 0, COUNT = 0, CMP = 32'hFFFF_FFFF, CTRL = 0, ERRCNT = 0.
  - bus_err = 0, timer_irq = 0.
  - RAM is not reset; its contents are retained or undefined.
- Reset asserted mid-access: the write is dropped; outputs take their reset values immediately.
- Release: the first edge after rst_n rises is a normal cycle.
- No handshakes or stall outputs: every access completes in the cycle it is presented.

## Test plan
- RAM write/readback: write 0x1234_5678 to 0x0000_0010; next cycle read 0x0000_0010 → 0x1234_5678. Read 0x0000_0013 → same value (low bits ignored).
- Read-during-write: RAM[4] = 0xA; present MemRead = MemWrite = 1, bWData = 0xB at 0x10 → bRData = 0xA that cycle, 0xB next cycle.
- LED register: write 0xFFFF_ABCD to 0x8000_0000 → leds = 0xABCD after the edge; read returns 0x0000_ABCD. Pulse rst_n → leds = 0 immediately.
- Timer match with auto-clear: CMP = 5, CTRL = 0xB (EN, AUTO_CLR, IRQ_EN), COUNT = 0. Expect COUNT 0..5, MATCH set and COUNT → 0, timer_irq = 1. Write CTRL = 0xF → MATCH clears, irq drops. Writing 1 to MATCH on the exact match cycle leaves MATCH = 1.
- Timer wrap and override: COUNT = 0xFFFF_FFFE, CMP = 3, EN = 1 → 0xFFFF_FFFF, 0, 1 with no MATCH. A write of 0x100 to COUNT on an enabled cycle → next COUNT = 0x100.
- Bus error: read 0x4000_0000 → bRData = 0, bus_err pulses one cycle, ERRCNT = 1. Write 0x8000_0014 → ERRCNT = 2. Preload 0xFFFF errors → ERRCNT stays 0xFFFF.
